// File: rtl/triangle_scan.sv
// Triangle rasterizer front end: computes the triangle's bounding box, clamps it to the
// screen, and walks it in raster order, emitting one candidate pixel per handshake.
module triangle_scan #(
    parameter int SCREEN_WIDTH  = 320,
    parameter int SCREEN_HEIGHT = 240
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   valid_in,
    output logic                   ready_out,
    input  logic [2:0][1:0][16:0]  vertices_in,
    input  logic                   ready_in,
    output logic                   valid_out,
    output logic [1:0][16:0]       point_out,
    output logic [2:0][1:0][16:0]  vertices_out,
    output logic                   last_out
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] BOUND = 2'd1;
    localparam logic [1:0] CLAMP = 2'd2;
    localparam logic [1:0] SCAN  = 2'd3;

    localparam logic signed [16:0] X_LIM = 17'(SCREEN_WIDTH - 1);
    localparam logic signed [16:0] Y_LIM = 17'(SCREEN_HEIGHT - 1);

    logic [1:0]              state_r;
    logic [2:0][1:0][16:0]   verts_r;
    logic signed [16:0]      xmin_r, xmax_r, ymin_r, ymax_r;
    logic signed [16:0]      x_r, y_r;
    logic                    valid_r, last_r;

    logic signed [16:0]      bxmin_s, bxmax_s, bymin_s, bymax_s;
    logic signed [16:0]      cxmin_s, cxmax_s, cymin_s, cymax_s;
    logic signed [16:0]      x_inc_s, y_inc_s;
    logic                    empty_s;
    logic                    xfer_s;

    function automatic logic signed [16:0] min3(input logic signed [16:0] a,
                                                input logic signed [16:0] b,
                                                input logic signed [16:0] c);
        logic signed [16:0] m;
        m = (a < b) ? a : b;
        m = (c < m) ? c : m;
        return m;
    endfunction

    function automatic logic signed [16:0] max3(input logic signed [16:0] a,
                                                input logic signed [16:0] b,
                                                input logic signed [16:0] c);
        logic signed [16:0] m;
        m = (a > b) ? a : b;
        m = (c > m) ? c : m;
        return m;
    endfunction

    // Raw bounding box of the held vertices
    always_comb begin
        bxmin_s = min3($signed(verts_r[0][0]), $signed(verts_r[1][0]), $signed(verts_r[2][0]));
        bxmax_s = max3($signed(verts_r[0][0]), $signed(verts_r[1][0]), $signed(verts_r[2][0]));
        bymin_s = min3($signed(verts_r[0][1]), $signed(verts_r[1][1]), $signed(verts_r[2][1]));
        bymax_s = max3($signed(verts_r[0][1]), $signed(verts_r[1][1]), $signed(verts_r[2][1]));
    end

    // Screen clipping of the registered box, plus the fully off-screen test
    always_comb begin
        empty_s = (xmax_r < 17'sd0) || (ymax_r < 17'sd0) || (xmin_r > X_LIM) || (ymin_r > Y_LIM);
        if (xmin_r < 17'sd0) begin
            cxmin_s = 17'sd0;
        end else begin
            cxmin_s = xmin_r;
        end
        if (ymin_r < 17'sd0) begin
            cymin_s = 17'sd0;
        end else begin
            cymin_s = ymin_r;
        end
        if (xmax_r > X_LIM) begin
            cxmax_s = X_LIM;
        end else begin
            cxmax_s = xmax_r;
        end
        if (ymax_r > Y_LIM) begin
            cymax_s = Y_LIM;
        end else begin
            cymax_s = ymax_r;
        end
    end

    // Scan stepping helpers
    always_comb begin
        x_inc_s = x_r + 17'sd1;
        y_inc_s = y_r + 17'sd1;
        xfer_s  = valid_r && ready_in;
    end

    // Control FSM together with the box, point and vertex registers
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_r <= IDLE;
            verts_r <= '0;
            xmin_r  <= 17'sd0;
            xmax_r  <= 17'sd0;
            ymin_r  <= 17'sd0;
            ymax_r  <= 17'sd0;
            x_r     <= 17'sd0;
            y_r     <= 17'sd0;
            valid_r <= 1'b0;
            last_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (valid_in) begin
                        verts_r <= vertices_in;
                        state_r <= BOUND;
                    end
                end
                BOUND: begin
                    xmin_r  <= bxmin_s;
                    xmax_r  <= bxmax_s;
                    ymin_r  <= bymin_s;
                    ymax_r  <= bymax_s;
                    state_r <= CLAMP;
                end
                CLAMP: begin
                    if (empty_s) begin
                        state_r <= IDLE;
                    end else begin
                        xmin_r  <= cxmin_s;
                        xmax_r  <= cxmax_s;
                        ymin_r  <= cymin_s;
                        ymax_r  <= cymax_s;
                        x_r     <= cxmin_s;
                        y_r     <= cymin_s;
                        valid_r <= 1'b1;
                        last_r  <= (cxmin_s == cxmax_s) && (cymin_s == cymax_s);
                        state_r <= SCAN;
                    end
                end
                SCAN: begin
                    // last_r is precomputed for the point being loaded, so it rides with it
                    if (xfer_s) begin
                        if (x_r != xmax_r) begin
                            x_r    <= x_inc_s;
                            last_r <= (x_inc_s == xmax_r) && (y_r == ymax_r);
                        end else if (y_r != ymax_r) begin
                            x_r    <= xmin_r;
                            y_r    <= y_inc_s;
                            last_r <= (xmin_r == xmax_r) && (y_inc_s == ymax_r);
                        end else begin
                            valid_r <= 1'b0;
                            last_r  <= 1'b0;
                            state_r <= IDLE;
                        end
                    end
                end
                default: begin
                    valid_r <= 1'b0;
                    last_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // Output mapping from registered state
    always_comb begin
        ready_out    = (state_r == IDLE);
        valid_out    = valid_r;
        last_out     = last_r;
        point_out    = {y_r, x_r};
        vertices_out = verts_r;
    end

endmodule

// File: tb/tb_triangle_scan.sv
// Directed, table-driven bench for triangle_scan: raster order, latency, backpressure,
// clamping, off-screen rejection, single pixel, and reset during a scan.
module tb_triangle_scan;

    logic                  clk_in = 1'b0;
    logic                  rst_in = 1'b1;
    logic                  valid_in = 1'b0;
    logic                  ready_out;
    logic [2:0][1:0][16:0] vertices_in = '0;
    logic                  ready_in = 1'b1;
    logic                  valid_out;
    logic [1:0][16:0]      point_out;
    logic [2:0][1:0][16:0] vertices_out;
    logic                  last_out;

    int nvec = 0;
    int nerr = 0;

    triangle_scan #(.SCREEN_WIDTH(320), .SCREEN_HEIGHT(240)) dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .valid_in    (valid_in),
        .ready_out   (ready_out),
        .vertices_in (vertices_in),
        .ready_in    (ready_in),
        .valid_out   (valid_out),
        .point_out   (point_out),
        .vertices_out(vertices_out),
        .last_out    (last_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct packed {
        logic [2:0][1:0][16:0] v;
        logic [3:0]            npts;
        logic [5:0][16:0]      ex;
        logic [5:0][16:0]      ey;
        logic                  bp;
    } vec_t;

    vec_t tv[6];

    function automatic logic [2:0][1:0][16:0] mkv(input int x0, input int y0, input int x1,
                                                  input int y1, input int x2, input int y2);
        logic [2:0][1:0][16:0] r;
        r[0][0] = 17'(x0); r[0][1] = 17'(y0);
        r[1][0] = 17'(x1); r[1][1] = 17'(y1);
        r[2][0] = 17'(x2); r[2][1] = 17'(y2);
        return r;
    endfunction

    function automatic logic [5:0][16:0] mkp(input int a0, input int a1, input int a2,
                                             input int a3, input int a4, input int a5);
        logic [5:0][16:0] r;
        r[0] = 17'(a0); r[1] = 17'(a1); r[2] = 17'(a2);
        r[3] = 17'(a3); r[4] = 17'(a4); r[5] = 17'(a5);
        return r;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge after the last transfer.
    task automatic run_tri(input vec_t t);
        int got;
        int cyc;
        bit held;
        logic [1:0][16:0] snap_pt;
        logic snap_last;
        got  = 0;
        cyc  = 0;
        held = 1'b0;
        snap_pt = '0;
        snap_last = 1'b0;
        check("ready_idle", 128'(ready_out), 128'(1'b1));
        vertices_in = t.v;
        valid_in = 1'b1;
        ready_in = 1'b1;
        @(negedge clk_in);
        valid_in = 1'b0;
        vertices_in = '0;
        check("lat_bound_valid", 128'(valid_out), 128'(1'b0));
        @(negedge clk_in);
        check("lat_clamp_valid", 128'(valid_out), 128'(1'b0));
        @(negedge clk_in);
        if (t.npts == 4'd0) begin
            check("empty_valid", 128'(valid_out), 128'(1'b0));
            check("empty_ready", 128'(ready_out), 128'(1'b1));
            return;
        end
        check("first_valid", 128'(valid_out), 128'(1'b1));
        while (got < int'(t.npts) && cyc < 100) begin
            if (held) begin
                check("hold_valid", 128'(valid_out), 128'(1'b1));
                check("hold_point", 128'(point_out), 128'(snap_pt));
                check("hold_last", 128'(last_out), 128'(snap_last));
            end
            ready_in = t.bp ? (cyc % 2 == 0) : 1'b1;
            if (ready_in && valid_out) begin
                check("point", 128'(point_out), 128'({t.ey[got], t.ex[got]}));
                check("last", 128'(last_out), 128'(got == int'(t.npts) - 1));
                check("vertices_out", 128'(vertices_out), 128'(t.v));
                got++;
                held = 1'b0;
            end else begin
                held = ~ready_in;
                snap_pt = point_out;
                snap_last = last_out;
            end
            @(negedge clk_in);
            cyc++;
        end
        if (got < int'(t.npts)) begin
            nvec++;
            nerr++;
            $display("FAIL scan_timeout: got %0d points expected %0d", got, t.npts);
        end
        ready_in = 1'b1;
        check("done_valid", 128'(valid_out), 128'(1'b0));
        check("done_ready", 128'(ready_out), 128'(1'b1));
    endtask

    initial begin
        tv[0] = '{v: mkv(10, 20, 12, 20, 10, 21), npts: 4'd6,
                  ex: mkp(10, 11, 12, 10, 11, 12), ey: mkp(20, 20, 20, 21, 21, 21), bp: 1'b0};
        tv[1] = tv[0];
        tv[1].bp = 1'b1;
        tv[2] = '{v: mkv(-5, -3, 2, -3, -5, 1), npts: 4'd6,
                  ex: mkp(0, 1, 2, 0, 1, 2), ey: mkp(0, 0, 0, 1, 1, 1), bp: 1'b0};
        tv[3] = '{v: mkv(400, 10, 410, 10, 400, 20), npts: 4'd0,
                  ex: mkp(0, 0, 0, 0, 0, 0), ey: mkp(0, 0, 0, 0, 0, 0), bp: 1'b0};
        tv[4] = '{v: mkv(319, 239, 319, 239, 319, 239), npts: 4'd1,
                  ex: mkp(319, 0, 0, 0, 0, 0), ey: mkp(239, 0, 0, 0, 0, 0), bp: 1'b0};
        tv[5] = '{v: mkv(0, 0, 1, 0, 0, 0), npts: 4'd2,
                  ex: mkp(0, 1, 0, 0, 0, 0), ey: mkp(0, 0, 0, 0, 0, 0), bp: 1'b0};

        rst_in = 1'b1;
        valid_in = 1'b1;
        @(negedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b0;
        valid_in = 1'b0;
        check("rst_ready", 128'(ready_out), 128'(1'b1));
        check("rst_valid", 128'(valid_out), 128'(1'b0));
        check("rst_last", 128'(last_out), 128'(1'b0));
        check("rst_point", 128'(point_out), 128'(0));
        check("rst_vertices", 128'(vertices_out), 128'(0));

        for (int i = 0; i < 5; i++) begin
            run_tri(tv[i]);
        end

        // Abort the small triangle after two transfers
        check("pre_ready", 128'(ready_out), 128'(1'b1));
        vertices_in = tv[0].v;
        valid_in = 1'b1;
        ready_in = 1'b1;
        @(negedge clk_in);
        valid_in = 1'b0;
        @(negedge clk_in);
        @(negedge clk_in);
        check("abort_p0", 128'(point_out), 128'({17'd20, 17'd10}));
        @(negedge clk_in);
        check("abort_p1", 128'(point_out), 128'({17'd20, 17'd11}));
        @(negedge clk_in);
        rst_in = 1'b1;
        @(negedge clk_in);
        rst_in = 1'b0;
        check("abort_valid", 128'(valid_out), 128'(1'b0));
        check("abort_ready", 128'(ready_out), 128'(1'b1));
        check("abort_last", 128'(last_out), 128'(1'b0));
        check("abort_vertices", 128'(vertices_out), 128'(0));
        run_tri(tv[5]);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/triangle_scan.md
Name: triangle_scan

Overview:
- Rasterizer front end that sits directly upstream of the barycentric coefficient stage.
- Accepts one screen-space triangle at a time and computes its bounding box, clamped to the screen.
- Walks the box in raster order, emitting one candidate pixel per handshake.
- Each pixel is paired with the triangle's vertices, so the barycentric stage can decide coverage and weights.

Parameters:
- SCREEN_WIDTH, 320, number of pixel columns; legal x range is 0..SCREEN_WIDTH-1.
- SCREEN_HEIGHT, 240, number of pixel rows; legal y range is 0..SCREEN_HEIGHT-1.

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  synchronous, active-high reset.
- valid_in  input  1  upstream triangle valid.
- ready_out  output  1  block can accept a triangle; high only in IDLE.
- vertices_in  input  [2:0][1:0][16:0]  triangle vertices; [v][0]=x, [v][1]=y; signed two's complement, integer pixel units.
- ready_in  input  1  downstream can take a point.
- valid_out  output  1  point_out/vertices_out valid.
- point_out  output  [1:0][16:0]  pixel coordinate; [0]=x, [1]=y; same format as vertices_in.
- vertices_out  output  [2:0][1:0][16:0]  copy of the accepted vertices, constant for the whole scan.
- last_out  output  1  marks the final point of the current triangle.

Behaviour:
- Reset: synchronous, active-high. On a clock edge with rst_in=1:
  - state goes to IDLE;
  - valid_out=0, last_out=0;
  - point_out and vertices_out go to 0.
- ready_out is decoded from state, so it reads 1 from the first edge after reset.
- valid_in is ignored while rst_in=1.
- Handshakes:
  - Input transfer occurs on an edge where valid_in && ready_out.
  - Output transfer occurs on an edge where valid_out && ready_in.
  - While valid_out=1 and ready_in=0, point_out, vertices_out and last_out hold stable.
- FSM states: IDLE, BOUND, CLAMP, SCAN.
- IDLE:
  - ready_out=1.
  - On an input transfer, register vertices_in and go to BOUND.
- BOUND (1 cycle):
  - Register signed min and max of the three x values and of the three y values.
  - Go to CLAMP.
- CLAMP (1 cycle): checks in order:
  - Empty case: if xmax<0, ymax<0, xmin>SCREEN_WIDTH-1 or ymin>SCREEN_HEIGHT-1, the triangle is empty. Go to IDLE and emit no points.
  - Clamping: otherwise clamp xmin and ymin up to 0, xmax down to SCREEN_WIDTH-1, and ymax down to SCREEN_HEIGHT-1.
  - Scan start: load point=(xmin,ymin), set valid_out=1, and go to SCAN.
  - last_out=1 immediately if xmin==xmax and ymin==ymax.
- SCAN: on each output transfer, one of three cases applies:
  - If x!=xmax: x<=x+1.
  - Else if y!=ymax: x<=xmin, y<=y+1.
  - Else (the last_out beat): valid_out<=0, last_out<=0, go to IDLE.
  - last_out is set on the point (xmax,ymax) only.
- Latency:
  - First valid_out is 3 cycles after the input-transfer edge.
  - Throughput is 1 point per cycle while ready_in=1.
  - ready_out reasserts the cycle after the last transfer. There is no overlap between triangles.
- Point count per triangle: (xmax-xmin+1)*(ymax-ymin+1) after clamping. Zero-area and degenerate triangles are still scanned; coverage is decided downstream.
- Arithmetic:
  - All comparisons are signed 17-bit.
  - Counters never exceed the clamped bounds, so there is no overflow or wrap.
- Reset mid-operation: any state aborts to IDLE. A partial scan is discarded, and no last_out is emitted for the aborted triangle.

Test Plan:
- Small triangle: vertices (10,20),(12,20),(10,21), ready_in=1 -> 6 points (10,20),(11,20),(12,20),(10,21),(11,21),(12,21). First point 3 cycles after accept. last_out only on (12,21). ready_out high the next cycle.
- Backpressure: same triangle, ready_in toggling 1,0,1,0… -> identical 6-point sequence with no drops or duplicates. Outputs stable on every ready_in=0 cycle.
- Clamping: vertices (-5,-3),(2,-3),(-5,1) -> 6 points covering x 0..2, y 0..1 in raster order.
- Off-screen: vertices (400,10),(410,10),(400,20) -> valid_out never asserts. ready_out high again 3 cycles after accept.
- Single pixel: all vertices (319,239) -> exactly one point (319,239) with last_out=1. vertices_out equals the input vertices.
- Reset mid-scan: after 2 points of the small triangle, assert rst_in for 1 cycle.
  - Next cycle: valid_out=0, ready_out=1.
  - A new triangle (0,0),(1,0),(0,0) then yields exactly (0,0),(1,0), with last_out on (1,0).
